// File: rtl/prg_save.sv
// prg_save: streams the current BASIC program from RAM as a PRG image (load address + bytes).
module prg_save #(
  parameter logic [15:0] PTR_START = 16'h002B,
  parameter logic [15:0] PTR_END   = 16'h002D
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        err,
  output logic [15:0] size,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_din,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_last
);
  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] RD_SL = 4'd1;
  localparam logic [3:0] RD_SH = 4'd2;
  localparam logic [3:0] RD_EL = 4'd3;
  localparam logic [3:0] RD_EH = 4'd4;
  localparam logic [3:0] CHECK = 4'd5;
  localparam logic [3:0] HDR_L = 4'd6;
  localparam logic [3:0] HDR_H = 4'd7;
  localparam logic [3:0] FETCH = 4'd8;
  localparam logic [3:0] SEND  = 4'd9;
  localparam logic [3:0] DONE  = 4'd10;
  logic [3:0]  state;
  logic [15:0] s, e;
  assign busy = state != IDLE;
  // mem_addr doubles as the data read pointer once the header is under way
  always_ff @(posedge clk_sys)
    if (reset) begin
      state    <= IDLE;
      err      <= 1'b0;
      size     <= 16'd0;
      mem_addr <= 16'd0;
      mem_rd   <= 1'b0;
      o_data   <= 8'd0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      s        <= 16'd0;
      e        <= 16'd0;
    end else
      case (state)
        IDLE:
          if (start) begin
            err      <= 1'b0;
            mem_addr <= PTR_START;
            mem_rd   <= 1'b1;
            state    <= RD_SL;
          end
        RD_SL, RD_SH, RD_EL, RD_EH:
          if (!mem_rd) mem_rd <= 1'b1;
          else if (mem_ack) begin
            mem_rd <= 1'b0;
            if (state == RD_SL) s[7:0]  <= mem_din;
            if (state == RD_SH) s[15:8] <= mem_din;
            if (state == RD_EL) e[7:0]  <= mem_din;
            if (state == RD_EH) e[15:8] <= mem_din;
            mem_addr <= state == RD_SL ? PTR_START + 16'd1 : state == RD_SH ? PTR_END : PTR_END + 16'd1;
            state    <= state + 4'd1;
          end
        CHECK:
          if (e < s) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            size     <= e - s;
            mem_addr <= s;
            o_data   <= s[7:0];
            o_valid  <= 1'b1;
            state    <= HDR_L;
          end
        HDR_L:
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= HDR_H;
          end
        HDR_H:
          if (!o_valid) begin
            o_valid <= 1'b1;
            o_data  <= s[15:8];
            o_last  <= e == s;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            state   <= e == s ? DONE : FETCH;
          end
        FETCH:
          if (!mem_rd) mem_rd <= 1'b1;
          else if (mem_ack) begin
            mem_rd  <= 1'b0;
            o_data  <= mem_din;
            o_valid <= 1'b1;
            o_last  <= mem_addr + 16'd1 == e;
            state   <= SEND;
          end
        SEND:
          if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            if (!o_last) mem_addr <= mem_addr + 16'd1;
            state <= o_last ? DONE : FETCH;
          end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_prg_save.sv
// tb_prg_save: directed bench for prg_save with a RAM/sink model and per-cycle protocol checks.
module tb_prg_save;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mem_ack = 1'b0, i_ready = 1'b0;
  logic [7:0]  mem_din = 8'd0;
  logic        busy, err, mem_rd, o_valid, o_last;
  logic [15:0] size, mem_addr;
  logic [7:0]  o_data;

  always #5 clk = ~clk;

  prg_save dut (
    .clk_sys(clk), .reset(reset), .start(start), .busy(busy), .err(err), .size(size),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_din(mem_din),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last)
  );

  logic [7:0]  mem [0:65535];
  logic [7:0]  img [5];
  logic [8:0]  exp_q [$];
  logic [7:0]  got_q [$];
  logic [15:0] rd_q [$], exp_rd [$];
  int          tests = 0, fails = 0, falls = 0;
  int          bp = 0, dly = 0, rcnt = 0, wcnt = 0;
  bit          resp_en = 1'b1, exp_err;
  logic [15:0] exp_size;
  logic        pv = 0, pr = 0, pl = 0, pm = 0, pa = 0, pb = 0;
  logic [7:0]  pd = 0;
  logic [15:0] pma = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Expected image straight from the pointer bytes currently in RAM
  task automatic model();
    logic [15:0] s, e;
    int sa, ea;
    s = {mem[16'h002C], mem[16'h002B]};
    e = {mem[16'h002E], mem[16'h002D]};
    sa = int'(s);
    ea = int'(e);
    exp_q.delete();
    exp_rd.delete();
    exp_rd.push_back(16'h002B);
    exp_rd.push_back(16'h002C);
    exp_rd.push_back(16'h002D);
    exp_rd.push_back(16'h002E);
    exp_err = ea < sa;
    exp_size = e - s;
    if (!exp_err) begin
      exp_q.push_back({1'b0, s[7:0]});
      exp_q.push_back({sa == ea, s[15:8]});
      for (int a = sa; a < ea; a++) begin
        exp_q.push_back({a == ea - 1, mem[a[15:0]]});
        exp_rd.push_back(a[15:0]);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic dump(input int b, input int d, input bit inj);
    bit done = 0, injd = 0;
    int f0;
    bp = b;
    dly = d;
    got_q.delete();
    rd_q.delete();
    model();
    f0 = falls;
    pulse_start();
    chk("busy_on", busy, 1);
    chk("err_clr", err, 0);
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
      else if (inj && !injd && exp_rd.size() > 4 && mem_rd && mem_addr == exp_rd[4]) begin
        pulse_start();
        injd = 1;
      end
    end
    chk("finish", done, 1);
    repeat (3) @(negedge clk);
    chk("err", err, exp_err);
    if (!exp_err) chk("size", size, exp_size);
    chk("bytes_left", exp_q.size(), 0);
    chk("reads_n", rd_q.size(), exp_rd.size());
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) chk("read_addr", rd_q[i], exp_rd[i]);
    chk("busy_falls", falls - f0, 1);
    chk("busy_idle", busy, 0);
  endtask

  task automatic pin(input int n);
    chk("img_len", got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk("img_byte", got_q[i], img[i]);
  endtask

  task automatic chk_rst();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_size", size, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_data", o_data, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
  endtask

  // Memory responder: ack after dly idle cycles of a held request
  initial forever begin
    @(posedge clk); #1;
    if (!resp_en) rcnt = 0;
    else if (reset) begin
      mem_ack = 1'b0;
      rcnt = 0;
    end else if (mem_ack) mem_ack = 1'b0;
    else if (mem_rd) begin
      if (rcnt >= dly) begin
        mem_ack = 1'b1;
        mem_din = mem[mem_addr];
        rd_q.push_back(mem_addr);
        rcnt = 0;
      end else rcnt++;
    end else rcnt = 0;
  end

  // Sink: hold i_ready low for bp cycles on each offered byte
  initial forever begin
    @(posedge clk); #1;
    if (!o_valid) begin
      wcnt = 0;
      i_ready = bp == 0;
    end else if (wcnt >= bp) i_ready = 1'b1;
    else begin
      i_ready = 1'b0;
      wcnt++;
    end
  end

  // Compare process: protocol rules plus the stream against the model queue
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("last_needs_valid", o_last & ~o_valid, 0);
      if (pv && !pr) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, pd);
        chk("hold_last", o_last, pl);
      end
      if (pm && !pa) begin
        chk("hold_rd", mem_rd, 1);
        chk("hold_addr", mem_addr, pma);
      end
      if (pa) chk("rd_drop", mem_rd, 0);
      if (o_valid && i_ready) begin
        got_q.push_back(o_data);
        chk("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("stream", {o_last, o_data}, exp_q.pop_front());
      end
      if (pb && !busy) falls++;
    end
    pv = o_valid && !reset;
    pr = i_ready;
    pd = o_data;
    pl = o_last;
    pm = mem_rd && !reset;
    pa = mem_ack && mem_rd;
    pma = mem_addr;
    pb = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found = 0;
    img = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h002B] = 8'h01; mem[16'h002C] = 8'h10;
    mem[16'h002D] = 8'h04; mem[16'h002E] = 8'h10;
    mem[16'h1001] = 8'hAA; mem[16'h1002] = 8'hBB; mem[16'h1003] = 8'hCC;
    repeat (3) @(posedge clk);
    #1 chk_rst();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1 chk("start_in_reset", busy, 0);
    // normal dump
    dump(0, 0, 0);
    pin(5);
    chk("size_normal", size, 3);
    // empty program
    mem[16'h002D] = 8'h01;
    dump(0, 0, 0);
    pin(2);
    chk("size_empty", size, 0);
    chk("ptr_reads_only", rd_q.size(), 4);
    // end below start
    mem[16'h002C] = 8'h12;
    dump(0, 0, 0);
    chk("err_set", err, 1);
    chk("no_bytes", got_q.size(), 0);
    // backpressure and slow memory, also clears err
    mem[16'h002C] = 8'h10;
    mem[16'h002D] = 8'h04;
    dump(5, 7, 0);
    pin(5);
    chk("err_cleared", err, 0);
    // start while busy
    dump(1, 2, 1);
    pin(5);
    // reset during SEND of BB
    bp = 3;
    dly = 0;
    model();
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = o_valid && o_data == 8'hBB;
    end
    chk("saw_bb", found, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk_rst();
    resp_en = 1'b0;
    mem_din = 8'h55;
    mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    resp_en = 1'b1;
    chk("late_ack_busy", busy, 0);
    chk("late_ack_rd", mem_rd, 0);
    chk("late_ack_valid", o_valid, 0);
    chk("late_ack_addr", mem_addr, 0);
    exp_q.delete();
    dump(0, 0, 0);
    pin(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
